// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave register file with NUM_REGS 32-bit registers.
// The write and read channels have separate controllers. An out-of-range
// address gets an SLVERR response. WR_PULSE gives one pulse per committed write.
// Optional feature: define AXI_REG_WSTRB_EN to honour WSTRB byte strobes.
// When it is not defined, WSTRB is ignored and each write replaces the whole word.
module axi4lite_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]            REG_OUT,
  output logic [NUM_REGS-1:0]               WR_PULSE
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_DATA}           rd_state_e;

  // Write side state
  wr_state_e            wr_state_q, wr_state_d;
  logic                 aw_full_q, aw_full_d;
  logic                 w_full_q, w_full_d;
  logic                 awready_q, awready_d;
  logic                 wready_q, wready_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [IDX_W-1:0]     awidx_q, awidx_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [SW-1:0]        wstrb_q, wstrb_d;
  logic [DW-1:0]        regs_q [NUM_REGS];
  logic [DW-1:0]        regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]  wr_pulse_q, wr_pulse_d;

  // Read side state
  rd_state_e            rd_state_q, rd_state_d;
  logic                 arready_q, arready_d;
  logic                 rvalid_q, rvalid_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [DW-1:0]        rdata_q, rdata_d;

  logic [IDX_W-1:0]     aridx;
  logic [SEL_W-1:0]     wr_sel;
  logic [SEL_W-1:0]     rd_sel;

  // Only the word index matters. The byte-lane bits and the PROT fields are not used.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

`ifndef AXI_REG_WSTRB_EN
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb_q;
`endif

  assign aridx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_sel = awidx_q[SEL_W-1:0];
  assign rd_sel = aridx[SEL_W-1:0];

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return (int'(idx) < NUM_REGS);
  endfunction

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign WR_PULSE      = wr_pulse_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
    assign REG_OUT[32*k +: 32] = regs_q[k];
  end

  // Write controller: gather AW and W in any order, commit one edge later, then hold the B response.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_full_d  = aw_full_q;
    w_full_d   = w_full_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    awidx_d    = awidx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (S_AXI_AWVALID && awready_q) begin
          awidx_d   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          aw_full_d = 1'b1;
        end
        if (S_AXI_WVALID && wready_q) begin
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
          w_full_d = 1'b1;
        end
        if (aw_full_d && w_full_d) begin
          wr_state_d = W_COMMIT;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
        end else begin
          awready_d = !aw_full_d;
          wready_d  = !w_full_d;
        end
      end
      W_COMMIT: begin
        aw_full_d  = 1'b0;
        w_full_d   = 1'b0;
        bvalid_d   = 1'b1;
        wr_state_d = W_RESP;
        if (in_range(awidx_q)) begin
`ifdef AXI_REG_WSTRB_EN
          for (int b = 0; b < SW; b++) begin
            if (wstrb_q[b]) begin
              regs_d[wr_sel][8*b +: 8] = wdata_q[8*b +: 8];
            end
          end
`else
          regs_d[wr_sel] = wdata_q;
`endif
          wr_pulse_d[wr_sel] = 1'b1;
          bresp_d            = RESP_OKAY;
        end else begin
          bresp_d = RESP_SLVERR;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write-side and register-file flops
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q <= W_IDLE;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_q <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      wr_state_q <= wr_state_d;
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      awidx_q    <= awidx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  // Read controller: register data from the current contents on AR, then hold it until RREADY.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          if (in_range(aridx)) begin
            rdata_d = regs_q[rd_sel];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
          rvalid_d   = 1'b1;
          arready_d  = 1'b0;
          rd_state_d = R_DATA;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read-side flops
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Self-checking bench for axi4lite_reg_slave. It uses a vector table, a response
// scoreboard queue, and hand-written sequences for the multi-cycle corner cases.
module tb_axi4lite_reg_slave;

   logic         clk = 1'b0;
   logic         rstN;
   logic [4:0]   awAddr;
   logic [2:0]   awProt;
   logic         awValid;
   logic         awReady;
   logic [31:0]  wData;
   logic [3:0]   wStrb;
   logic         wValid;
   logic         wReady;
   logic [1:0]   bResp;
   logic         bValid;
   logic         bReady;
   logic [4:0]   arAddr;
   logic [2:0]   arProt;
   logic         arValid;
   logic         arReady;
   logic [31:0]  rData;
   logic [1:0]   rResp;
   logic         rValid;
   logic         rReady;
   logic [127:0] regOut;
   logic [3:0]   wrPulse;

   int checks = 0;
   int fails  = 0;

   logic [31:0] sbQ[$];
   logic [31:0] modelRegs [4];

   typedef struct {
      logic        isWrite;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] expData;
      logic [1:0]  expResp;
   } vec_t;

   vec_t vecs [16];

   axi4lite_reg_slave dut (
      .ACLK(clk), .ARESETN(rstN),
      .S_AXI_AWADDR(awAddr), .S_AXI_AWPROT(awProt), .S_AXI_AWVALID(awValid), .S_AXI_AWREADY(awReady),
      .S_AXI_WDATA(wData), .S_AXI_WSTRB(wStrb), .S_AXI_WVALID(wValid), .S_AXI_WREADY(wReady),
      .S_AXI_BRESP(bResp), .S_AXI_BVALID(bValid), .S_AXI_BREADY(bReady),
      .S_AXI_ARADDR(arAddr), .S_AXI_ARPROT(arProt), .S_AXI_ARVALID(arValid), .S_AXI_ARREADY(arReady),
      .S_AXI_RDATA(rData), .S_AXI_RRESP(rResp), .S_AXI_RVALID(rValid), .S_AXI_RREADY(rReady),
      .REG_OUT(regOut), .WR_PULSE(wrPulse)
   );

   // Free-running clock, 10 time-unit period
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic reportTimeout(input string name);
      checks++;
      fails++;
      $display("[TB] FAIL %s: timed out waiting, expected a handshake", name);
   endtask

   task automatic sbCheck(input string name, input logic [31:0] act);
      logic [31:0] exp;
      if (sbQ.size() == 0) begin
         reportTimeout({name, "_sb_empty"});
      end else begin
         exp = sbQ.pop_front();
         checkOutput(name, {96'b0, act}, {96'b0, exp});
      end
   endtask

   function automatic logic [127:0] modelFlat();
      return {modelRegs[3], modelRegs[2], modelRegs[1], modelRegs[0]};
   endfunction

   task automatic modelWrite(input int idx, input logic [31:0] data, input logic [3:0] strb);
`ifdef AXI_REG_WSTRB_EN
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) modelRegs[idx][8*b +: 8] = data[8*b +: 8];
      end
`else
      modelRegs[idx] = data;
      if (strb == 4'hx) modelRegs[idx] = data;
`endif
   endtask

   task automatic writeTxn(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] expResp);
      int guard;
      int idx;
      logic awHs;
      logic wHs;
      logic [3:0] expPulse;
      idx = int'(addr[4:2]);
      @(negedge clk);
      awAddr  = addr;
      wData   = data;
      wStrb   = strb;
      awValid = 1'b1;
      wValid  = 1'b1;
      bReady  = 1'b1;
      sbQ.push_back({30'b0, expResp});
      expPulse = 4'b0000;
      if (idx < 4) begin
         expPulse[idx] = 1'b1;
         modelWrite(idx, data, strb);
      end
      guard = 0;
      while ((awValid || wValid) && guard < 20) begin
         awHs = awValid && awReady;
         wHs  = wValid && wReady;
         @(posedge clk);
         #1;
         if (awHs) awValid = 1'b0;
         if (wHs)  wValid  = 1'b0;
         @(negedge clk);
         guard++;
      end
      if (awValid || wValid) begin
         reportTimeout("aw_w_handshake");
         awValid = 1'b0;
         wValid  = 1'b0;
      end
      guard = 0;
      while (!bValid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!bValid) begin
         reportTimeout("bvalid");
         void'(sbQ.pop_front());
      end else begin
         checkOutput("wr_pulse", {124'b0, wrPulse}, {124'b0, expPulse});
         sbCheck("bresp", {30'b0, bResp});
         checkOutput("reg_out_after_write", regOut, modelFlat());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic readTxn(input logic [4:0] addr, input logic [31:0] expData, input logic [1:0] expResp);
      int guard;
      @(negedge clk);
      arAddr  = addr;
      arValid = 1'b1;
      rReady  = 1'b1;
      sbQ.push_back(expData);
      sbQ.push_back({30'b0, expResp});
      guard = 0;
      while (!arReady && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!arReady) reportTimeout("arready");
      @(posedge clk);
      #1;
      arValid = 1'b0;
      guard = 0;
      @(negedge clk);
      while (!rValid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!rValid) begin
         reportTimeout("rvalid");
         void'(sbQ.pop_front());
         void'(sbQ.pop_front());
      end else begin
         sbCheck("rdata", rData);
         sbCheck("rresp", {30'b0, rResp});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      if (v.isWrite) writeTxn(v.addr, v.data, v.strb, v.expResp);
      else           readTxn(v.addr, v.expData, v.expResp);
   endtask

   initial begin
      rstN = 1'b0; awAddr = '0; awProt = 3'b101; awValid = 1'b0; wData = '0; wStrb = '0;
      wValid = 1'b0; bReady = 1'b0; arAddr = '0; arProt = 3'b010; arValid = 1'b0; rReady = 1'b0;
      for (int k = 0; k < 4; k++) modelRegs[k] = '0;

      vecs[0]  = '{1'b1, 5'h00, 32'h1, 4'hF, 32'h0, 2'b00};
      vecs[1]  = '{1'b1, 5'h04, 32'h2, 4'hF, 32'h0, 2'b00};
      vecs[2]  = '{1'b1, 5'h08, 32'h3, 4'hF, 32'h0, 2'b00};
      vecs[3]  = '{1'b1, 5'h0C, 32'h4, 4'hF, 32'h0, 2'b00};
      vecs[4]  = '{1'b0, 5'h00, 32'h0, 4'h0, 32'h1, 2'b00};
      vecs[5]  = '{1'b0, 5'h04, 32'h0, 4'h0, 32'h2, 2'b00};
      vecs[6]  = '{1'b0, 5'h08, 32'h0, 4'h0, 32'h3, 2'b00};
      vecs[7]  = '{1'b0, 5'h0C, 32'h0, 4'h0, 32'h4, 2'b00};
      vecs[8]  = '{1'b1, 5'h00, 32'h11223344, 4'hF, 32'h0, 2'b00};
      vecs[9]  = '{1'b1, 5'h00, 32'hAABBCCDD, 4'b0101, 32'h0, 2'b00};
`ifdef AXI_REG_WSTRB_EN
      vecs[10] = '{1'b0, 5'h00, 32'h0, 4'h0, 32'h11BB33DD, 2'b00};
`else
      vecs[10] = '{1'b0, 5'h00, 32'h0, 4'h0, 32'hAABBCCDD, 2'b00};
`endif
      vecs[11] = '{1'b1, 5'h00, 32'h1, 4'hF, 32'h0, 2'b00};
      vecs[12] = '{1'b1, 5'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b10};
      vecs[13] = '{1'b0, 5'h10, 32'h0, 4'h0, 32'h0, 2'b10};
      vecs[14] = '{1'b0, 5'h1F, 32'h0, 4'h0, 32'h0, 2'b10};
      vecs[15] = '{1'b0, 5'h0E, 32'h0, 4'h0, 32'h4, 2'b00};

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_awready", {127'b0, awReady}, 128'd0);
      checkOutput("rst_wready",  {127'b0, wReady},  128'd0);
      checkOutput("rst_arready", {127'b0, arReady}, 128'd0);
      checkOutput("rst_bvalid",  {127'b0, bValid},  128'd0);
      checkOutput("rst_rvalid",  {127'b0, rValid},  128'd0);
      checkOutput("rst_reg_out", regOut, 128'd0);
      checkOutput("rst_wr_pulse", {124'b0, wrPulse}, 128'd0);
      rstN = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rel_awready", {127'b0, awReady}, 128'd1);
      checkOutput("rel_wready",  {127'b0, wReady},  128'd1);
      checkOutput("rel_arready", {127'b0, arReady}, 128'd1);

      // Basic writes and readback
      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
      checkOutput("reg_out_4321", regOut, {32'h4, 32'h3, 32'h2, 32'h1});
      for (int i = 8; i < 16; i++) applyStimulus(vecs[i]);
      checkOutput("reg_out_after_oor", regOut, {32'h4, 32'h3, 32'h2, 32'h1});

      // W arrives three cycles before AW, and BREADY is held low for five cycles
      @(negedge clk);
      wData = 32'h77; wStrb = 4'hF; wValid = 1'b1; bReady = 1'b0;
      sbQ.push_back(32'h0);
      @(posedge clk); #1; wValid = 1'b0;
      @(negedge clk);
      checkOutput("wfirst_wready", {127'b0, wReady}, 128'd0);
      checkOutput("wfirst_awready", {127'b0, awReady}, 128'd1);
      checkOutput("wfirst_bvalid", {127'b0, bValid}, 128'd0);
      @(posedge clk); @(posedge clk); #1;
      awAddr = 5'h08; awValid = 1'b1;
      @(posedge clk); #1; awValid = 1'b0;
      @(negedge clk);
      checkOutput("wfirst_awready_drop", {127'b0, awReady}, 128'd0);
      checkOutput("wfirst_no_early_commit", {96'b0, regOut[95:64]}, 128'h3);
      @(negedge clk);
      modelRegs[2] = 32'h77;
      checkOutput("wfirst_bvalid_up", {127'b0, bValid}, 128'd1);
      checkOutput("wfirst_pulse", {124'b0, wrPulse}, 128'h4);
      checkOutput("wfirst_reg_out", regOut, modelFlat());
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("bhold_bvalid", {127'b0, bValid}, 128'd1);
         checkOutput("bhold_ready", {126'b0, awReady, wReady}, 128'd0);
      end
      checkOutput("bhold_pulse_gone", {124'b0, wrPulse}, 128'd0);
      sbCheck("wfirst_bresp", {30'b0, bResp});
      bReady = 1'b1;
      @(negedge clk);
      checkOutput("bdone_bvalid", {127'b0, bValid}, 128'd0);
      checkOutput("bdone_ready", {126'b0, awReady, wReady}, 128'd3);

      // The read handshake lands on the edge that commits the write to reg1
      @(negedge clk);
      awAddr = 5'h04; wData = 32'h55; wStrb = 4'hF; awValid = 1'b1; wValid = 1'b1;
      bReady = 1'b1; rReady = 1'b1;
      @(posedge clk); #1; awValid = 1'b0; wValid = 1'b0;
      arAddr = 5'h04; arValid = 1'b1;
      @(posedge clk); #1; arValid = 1'b0;
      @(negedge clk);
      modelRegs[1] = 32'h55;
      checkOutput("rw_rvalid", {127'b0, rValid}, 128'd1);
      checkOutput("rw_rdata_old", {96'b0, rData}, 128'h2);
      checkOutput("rw_bvalid", {127'b0, bValid}, 128'd1);
      checkOutput("rw_reg_out", regOut, modelFlat());
      @(negedge clk);
      checkOutput("rw_done", {126'b0, rValid, bValid}, 128'd0);
      readTxn(5'h04, 32'h55, 2'b00);

      // Reset while both BVALID and RVALID are high
      @(negedge clk);
      awAddr = 5'h0C; wData = 32'h99; awValid = 1'b1; wValid = 1'b1; bReady = 1'b0;
      arAddr = 5'h00; arValid = 1'b1; rReady = 1'b0;
      @(posedge clk); #1; awValid = 1'b0; wValid = 1'b0; arValid = 1'b0;
      @(negedge clk); @(negedge clk);
      checkOutput("prerst_valids", {126'b0, bValid, rValid}, 128'd3);
      #2 rstN = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) modelRegs[k] = '0;
      checkOutput("midrst_valids", {126'b0, bValid, rValid}, 128'd0);
      checkOutput("midrst_reg_out", regOut, 128'd0);
      checkOutput("midrst_readies", {125'b0, awReady, wReady, arReady}, 128'd0);
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk); #1;
      checkOutput("postrst_readies", {125'b0, awReady, wReady, arReady}, 128'd7);
      bReady = 1'b1;
      readTxn(5'h0C, 32'h0, 2'b00);

      checkOutput("sb_empty", 128'(sbQ.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      fails++;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/axi4lite_reg_slave.md
# axi4lite_reg_slave

AXI4-Lite slave register file that terminates the AXI VIP master transactions in the basic_integration IP and exposes its registers to user logic. It holds NUM_REGS 32-bit read/write registers with independent write and read channel controllers. It decodes out-of-range addresses to SLVERR. It also emits a one-cycle write-commit pulse per register for downstream logic.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; word index = addr[ADDR_WIDTH-1:2].
- NUM_REGS, 4, implemented registers at word indices 0..NUM_REGS-1; all other word indices are out of range.
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- REG_OUT  out  NUM_REGS*32  flattened register contents; register k is at [32k+31:32k].
- WR_PULSE  out  NUM_REGS  one-cycle pulse on register k in the cycle after its write commits.

## Operation
- Reset values: all registers 0, all outputs 0 (ready signals, valid signals, RDATA, BRESP, RRESP, WR_PULSE).
- Write FSM states:
  - IDLE: AWREADY=1, WREADY=1.
  - Each address or data handshake latches that channel and drops its own READY. AW and W may arrive in either order or in the same cycle.
  - When both are latched, the write commits on the next edge and the FSM enters RESP.
  - In-range commit: update the register, return OKAY, pulse WR_PULSE[k].
  - Out-of-range commit: the register file is unchanged, BRESP=SLVERR, no pulse.
  - RESP: BVALID=1; AWREADY=WREADY=0. BVALID holds until BREADY, then the FSM returns to IDLE.
- Read FSM states:
  - IDLE: ARREADY=1.
  - On the AR handshake, RDATA/RRESP are registered from the current register contents and the FSM enters DATA.
  - Out-of-range read returns RDATA=0, RRESP=SLVERR.
  - DATA: RVALID=1, ARREADY=0. RDATA, RRESP and RVALID stay stable until RREADY, then the FSM returns to IDLE.
- The read and write channels are fully independent and may be active in the same cycle.
- Read and write to the same register at the same edge: the read returns the pre-write value.
- AWPROT, ARPROT and the address bits [1:0] are ignored.

## Timing
- Write, AW and W in the same cycle (edge N): commit at edge N+1, BVALID high after edge N+1. WR_PULSE is high for the one cycle after the commit edge.
- Write, AW and W in different cycles: commit on the edge after the later handshake.
- Read: AR handshake at edge N gives RVALID high after edge N (one-cycle latency).
- After a B or R handshake at edge M, the corresponding READY signals are high after edge M. Maximum throughput is one write every 3 cycles and one read every 2 cycles.
- Reset mid-transaction: all latched state and valids clear asynchronously, and pending transactions are dropped. After ARESETN deasserts, the READY signals go high on the first rising edge.

## Configuration
- AXI_REG_WSTRB_EN defined: only the bytes with WSTRB[b]=1 are written. A write with WSTRB=0000 still commits (OKAY and WR_PULSE) with no data change.
- Not defined: WSTRB is ignored and every committed write replaces the full 32-bit word.

## Test plan
- Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, then read them back -> RDATA matches each value, all BRESP/RRESP=00, and REG_OUT equals {4,3,2,1}.
- With AXI_REG_WSTRB_EN, reg0=0x11223344, write 0xAABBCCDD with WSTRB=0101 -> readback 0x11BB33DD. Without the macro -> readback 0xAABBCCDD.
- Write 0xDEADBEEF to 0x10, then read 0x10 -> BRESP=10, RRESP=10, RDATA=0, WR_PULSE stays 0, and REG_OUT is unchanged.
- Present W 3 cycles before AW with BREADY held low for 5 cycles -> WREADY drops after the W handshake, the commit follows the AW handshake, and BVALID stays high with AWREADY=WREADY=0 until BREADY.
- Read and write 0x55 to reg1 (previously 0x2) in the same cycle -> RDATA=0x2, and a subsequent read returns 0x55.
- Assert ARESETN low while BVALID and RVALID are high -> both clear immediately, REG_OUT=0, and the READY signals are high on the first edge after release.
